// File: rtl/b10_peer.sv
`default_nettype none
// ============================================================================
//  Module   : b10_peer
//  Purpose  : Remote counterpart of the b10 voting terminal. It checks the
//             parity of each vote word, tallies green/red votes once per
//             transaction, and replies with a parity-corrected echo or the
//             terminating ACK word (4'b0110).
//  Options  : PEER_TIMEOUT_EN - enables the per-state watchdog (TIMEOUT cycles)
//  Revision : 1.0 - initial release
// ============================================================================
module b10_peer #(
    parameter int CNT_W      = 8,
    parameter int MAX_ROUNDS = 4,
    parameter int TIMEOUT    = 1024
) (
    input  logic             clk_i,
    input  logic             rst_n_i,
    input  logic             enable_i,
    input  logic             cts_i,
    input  logic             ctr_i,
    input  logic [3:0]       v_out_i,
    output logic             rtr_o,
    output logic             rts_o,
    output logic [3:0]       v_in_o,
    output logic [CNT_W-1:0] green_cnt_o,
    output logic [CNT_W-1:0] red_cnt_o,
    output logic [CNT_W-1:0] txn_cnt_o,
    output logic [CNT_W-1:0] err_cnt_o,
    output logic             busy_o,
    output logic             done_o,
    output logic             abort_o
);

    localparam logic [3:0] c_ACK = 4'b0110;
    localparam int         RW    = $clog2(MAX_ROUNDS + 1);

    typedef enum logic [2:0] {
        S_IDLE         = 3'd0,
        S_READY        = 3'd1,
        S_WAIT_CTR     = 3'd2,
        S_WAIT_CTR_LOW = 3'd3,
        S_WAIT_CTS_LOW = 3'd4,
        S_END_WAIT     = 3'd5
    } state_t;

    state_t            state_q;
    logic              rtr_q;
    logic              rts_q;
    logic [3:0]        v_in_q;
    logic [3:0]        reply_q;
    logic [RW-1:0]     rounds_q;
    logic              tallied_q;
    logic [CNT_W-1:0]  green_q;
    logic [CNT_W-1:0]  red_q;
    logic [CNT_W-1:0]  txn_q;
    logic [CNT_W-1:0]  err_q;
    logic              busy_q;
    logic              done_q;

    logic              par_ok_d;
    logic [RW-1:0]     rounds_d;
    logic [3:0]        reply_d;

    // Counters stick at all-ones instead of wrapping.
    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] v);
        return (&v) ? v : v + 1'b1;
    endfunction

    // Parity check and reply selection for the word currently on v_out.
    always_comb begin
        par_ok_d = (v_out_i[3] == ^v_out_i[2:0]);
        rounds_d = (rounds_q == RW'(MAX_ROUNDS)) ? rounds_q : rounds_q + 1'b1;
        if (par_ok_d || (rounds_d >= RW'(MAX_ROUNDS))) begin
            reply_d = c_ACK;
        end else begin
            reply_d = {^v_out_i[2:0], v_out_i[2:0]};
        end
    end

`ifdef PEER_TIMEOUT_EN
    localparam int WW = $clog2(TIMEOUT + 1);
    logic [WW-1:0] wd_q;
    logic          abort_q;
    logic          adv_d;

    // Flags cycles in which the FSM leaves its current state.
    always_comb begin
        case (state_q)
            S_IDLE:         adv_d = enable_i;
            S_READY:        adv_d = cts_i;
            S_WAIT_CTR:     adv_d = ctr_i;
            S_WAIT_CTR_LOW: adv_d = ~ctr_i;
            S_WAIT_CTS_LOW: adv_d = ~cts_i;
            S_END_WAIT:     adv_d = ~cts_i;
            default:        adv_d = 1'b1;
        endcase
    end

    assign abort_o = abort_q;
`else
    // No watchdog in this build; the comparison only keeps TIMEOUT referenced.
    assign abort_o = (TIMEOUT < 0) ? 1'b1 : 1'b0;
`endif

    // Handshake FSM, tallies and registered outputs.
    always_ff @(posedge clk_i or negedge rst_n_i) begin
        if (!rst_n_i) begin
            state_q   <= S_IDLE;
            rtr_q     <= 1'b0;
            rts_q     <= 1'b0;
            v_in_q    <= 4'b0000;
            reply_q   <= 4'b0000;
            rounds_q  <= '0;
            tallied_q <= 1'b0;
            green_q   <= '0;
            red_q     <= '0;
            txn_q     <= '0;
            err_q     <= '0;
            busy_q    <= 1'b0;
            done_q    <= 1'b0;
`ifdef PEER_TIMEOUT_EN
            wd_q      <= '0;
            abort_q   <= 1'b0;
`endif
        end else begin
            done_q <= 1'b0;
`ifdef PEER_TIMEOUT_EN
            abort_q <= 1'b0;
            wd_q    <= (adv_d || state_q == S_IDLE) ? '0 : wd_q + 1'b1;
            if (state_q != S_IDLE && wd_q == WW'(TIMEOUT - 1)) begin
                // Watchdog expiry: abandon the transaction without completing it.
                state_q <= S_IDLE;
                rtr_q   <= 1'b0;
                rts_q   <= 1'b0;
                busy_q  <= 1'b0;
                abort_q <= 1'b1;
                err_q   <= sat_inc(err_q);
                wd_q    <= '0;
            end else
`endif
            begin
                case (state_q)
                    S_IDLE: begin
                        rtr_q <= 1'b0;
                        rts_q <= 1'b0;
                        if (enable_i) begin
                            state_q   <= S_READY;
                            rtr_q     <= 1'b1;
                            busy_q    <= 1'b1;
                            rounds_q  <= '0;
                            tallied_q <= 1'b0;
                        end
                    end
                    S_READY: begin
                        if (cts_i) begin
                            if (v_out_i == c_ACK) begin
                                state_q <= S_END_WAIT;
                                rtr_q   <= 1'b0;
                            end else begin
                                if (!par_ok_d) begin
                                    err_q    <= sat_inc(err_q);
                                    rounds_q <= rounds_d;
                                end else if (!tallied_q) begin
                                    // Only the first good word of a transaction counts.
                                    if (v_out_i[1]) green_q <= sat_inc(green_q);
                                    if (v_out_i[2]) red_q   <= sat_inc(red_q);
                                    tallied_q <= 1'b1;
                                end
                                reply_q <= reply_d;
                                state_q <= S_WAIT_CTR;
                            end
                        end
                    end
                    S_WAIT_CTR: begin
                        if (ctr_i) begin
                            v_in_q  <= reply_q;
                            rts_q   <= 1'b1;
                            state_q <= S_WAIT_CTR_LOW;
                        end
                    end
                    S_WAIT_CTR_LOW: begin
                        if (!ctr_i) begin
                            rts_q   <= 1'b0;
                            rtr_q   <= 1'b0;
                            state_q <= S_WAIT_CTS_LOW;
                        end
                    end
                    S_WAIT_CTS_LOW: begin
                        // rtr may only rise once b10 has released cts.
                        if (!cts_i) begin
                            rtr_q   <= 1'b1;
                            state_q <= S_READY;
                        end
                    end
                    S_END_WAIT: begin
                        rtr_q <= 1'b0;
                        if (!cts_i) begin
                            txn_q   <= sat_inc(txn_q);
                            done_q  <= 1'b1;
                            busy_q  <= 1'b0;
                            state_q <= S_IDLE;
                        end
                    end
                    default: begin
                        state_q <= S_IDLE;
                        rtr_q   <= 1'b0;
                        rts_q   <= 1'b0;
                        busy_q  <= 1'b0;
                    end
                endcase
            end
        end
    end

    assign rtr_o       = rtr_q;
    assign rts_o       = rts_q;
    assign v_in_o      = v_in_q;
    assign green_cnt_o = green_q;
    assign red_cnt_o   = red_q;
    assign txn_cnt_o   = txn_q;
    assign err_cnt_o   = err_q;
    assign busy_o      = busy_q;
    assign done_o      = done_q;

endmodule
`default_nettype wire

// File: tb/tb_b10_peer.sv
`default_nettype none
// ============================================================================
//  Module   : tb_b10_peer
//  Purpose  : Scoreboard bench for b10_peer. A driver plays the b10 side of
//             the handshake and pushes expected replies/statistics from a
//             behavioural model; a monitor pops and compares them whenever
//             the peer raises rts or pulses done.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_b10_peer;

    localparam int         CNT_W = 3;
    localparam int         MAXR  = 2;
    localparam int         SATV  = (1 << CNT_W) - 1;
    localparam logic [3:0] ACK   = 4'b0110;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             enable;
    logic             cts;
    logic             ctr;
    logic [3:0]       v_out;
    logic             rtr;
    logic             rts;
    logic [3:0]       v_in;
    logic [CNT_W-1:0] green_cnt;
    logic [CNT_W-1:0] red_cnt;
    logic [CNT_W-1:0] txn_cnt;
    logic [CNT_W-1:0] err_cnt;
    logic             busy;
    logic             done;
    logic             abort;

    b10_peer #(.CNT_W(CNT_W), .MAX_ROUNDS(MAXR), .TIMEOUT(16)) dut (
        .clk_i(clk), .rst_n_i(rst_n), .enable_i(enable), .cts_i(cts),
        .ctr_i(ctr), .v_out_i(v_out), .rtr_o(rtr), .rts_o(rts), .v_in_o(v_in),
        .green_cnt_o(green_cnt), .red_cnt_o(red_cnt), .txn_cnt_o(txn_cnt),
        .err_cnt_o(err_cnt), .busy_o(busy), .done_o(done), .abort_o(abort)
    );

    always #5 clk = ~clk;

    typedef struct {
        bit         is_end;
        logic [3:0] vin;
        int         g;
        int         r;
        int         t;
        int         e;
    } exp_t;

    exp_t sb_q[$];

    int n_cmp = 0;
    int n_bad = 0;

    // Reference model state: totals plus per-transaction bookkeeping.
    int m_g = 0, m_r = 0, m_t = 0, m_e = 0, m_rounds = 0;
    bit m_tallied = 0;

    function automatic int sat1(input int v);
        return (v < SATV) ? v + 1 : v;
    endfunction

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    task automatic wait_sig(input int sel, input logic val, input string nm);
        int   n;
        logic s;
        n = 0;
        do begin
            @(negedge clk);
            n++;
            s = (sel == 0) ? rtr : (sel == 1) ? rts : done;
        end while (s !== val && n < 200);
        if (s !== val) begin
            n_cmp++;
            n_bad++;
            $display("FAIL %s: timed out, got %0b expected %0b", nm, s, val);
        end
    endtask

    // One word of b10 traffic, including the full handshake for its reply.
    task automatic send(input logic [3:0] w, input int hold, output logic [3:0] rep);
        exp_t e;
        bit   good;
        wait_sig(0, 1'b1, "rtr_ready");
        v_out = w;
        cts   = 1'b1;
        if (w == ACK) begin
            m_t = sat1(m_t);
            e = '{1'b1, 4'b0000, m_g, m_r, m_t, m_e};
            sb_q.push_back(e);
            wait_sig(0, 1'b0, "rtr_drop");
            repeat ($urandom % 3) @(negedge clk);
            cts = 1'b0;
            wait_sig(2, 1'b1, "done_seen");
            m_rounds  = 0;
            m_tallied = 0;
            rep = ACK;
        end else begin
            good = (w[3] == (w[2] ^ w[1] ^ w[0]));
            if (!good) begin
                m_e = sat1(m_e);
                m_rounds++;
            end else if (!m_tallied) begin
                if (w[1]) m_g = sat1(m_g);
                if (w[2]) m_r = sat1(m_r);
                m_tallied = 1;
            end
            e.is_end = 1'b0;
            e.vin    = (good || m_rounds >= MAXR) ? ACK : {w[2] ^ w[1] ^ w[0], w[2:0]};
            e.g = m_g; e.r = m_r; e.t = m_t; e.e = m_e;
            sb_q.push_back(e);
            repeat ($urandom % 3) @(negedge clk);
            ctr = 1'b1;
            wait_sig(1, 1'b1, "rts_rise");
            rep = v_in;
            repeat ($urandom % 3) @(negedge clk);
            ctr = 1'b0;
            wait_sig(1, 1'b0, "rts_fall");
            for (int i = 0; i < hold; i++) begin
                @(negedge clk);
                check("rtr_hold_low", {31'b0, rtr}, 32'd0);
            end
            cts = 1'b0;
            @(negedge clk);
            check("rtr_rise", {31'b0, rtr}, 32'd1);
        end
    endtask

    // Monitor: compares DUT presentations against the scoreboard.
    bit prev_rts  = 0;
    bit prev_done = 0;
    always @(negedge clk) begin
        exp_t e;
        if (rst_n) begin
            if (rts && !prev_rts) begin
                if (sb_q.size() == 0) begin
                    check("sb_reply_avail", 32'd0, 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_reply_kind", {31'b0, e.is_end}, 32'd0);
                    check("reply_v_in", {28'b0, v_in}, {28'b0, e.vin});
                    check("reply_green", {29'b0, green_cnt}, e.g);
                    check("reply_red", {29'b0, red_cnt}, e.r);
                    check("reply_err", {29'b0, err_cnt}, e.e);
                end
            end
            if (done) begin
                if (sb_q.size() == 0) begin
                    check("sb_done_avail", 32'd0, 32'd1);
                end else begin
                    e = sb_q.pop_front();
                    check("sb_done_kind", {31'b0, e.is_end}, 32'd1);
                    check("done_green", {29'b0, green_cnt}, e.g);
                    check("done_red", {29'b0, red_cnt}, e.r);
                    check("done_txn", {29'b0, txn_cnt}, e.t);
                    check("done_err", {29'b0, err_cnt}, e.e);
                    check("done_busy", {31'b0, busy}, 32'd0);
                end
            end
            if (prev_done) check("done_one_cycle", {31'b0, done}, 32'd0);
            prev_rts  = rts;
            prev_done = done;
        end else begin
            prev_rts  = 0;
            prev_done = 0;
        end
    end

    task automatic check_all_zero(input string tag);
        check({tag, "_rtr"}, {31'b0, rtr}, 32'd0);
        check({tag, "_rts"}, {31'b0, rts}, 32'd0);
        check({tag, "_v_in"}, {28'b0, v_in}, 32'd0);
        check({tag, "_green"}, {29'b0, green_cnt}, 32'd0);
        check({tag, "_red"}, {29'b0, red_cnt}, 32'd0);
        check({tag, "_txn"}, {29'b0, txn_cnt}, 32'd0);
        check({tag, "_err"}, {29'b0, err_cnt}, 32'd0);
        check({tag, "_busy"}, {31'b0, busy}, 32'd0);
        check({tag, "_done"}, {31'b0, done}, 32'd0);
    endtask

    initial begin
        logic [3:0] rep;
        logic [3:0] last;
        logic [3:0] w;
        int         nw;
        bit         ended;

        rst_n = 1'b0; enable = 1'b0; cts = 1'b0; ctr = 1'b0; v_out = 4'b0000;
        repeat (3) @(negedge clk);
        check_all_zero("reset");
        rst_n  = 1'b1;
        enable = 1'b1;

        // Good vote, bad-parity correction, forced ACK after MAX_ROUNDS.
        send(4'b0011, 0, rep);
        send(ACK, 0, rep);
        send(4'b1101, 0, rep);
        send(4'b0101, 10, rep);
        send(ACK, 0, rep);
        send(4'b1000, 1, rep);
        send(4'b1000, 0, rep);
        send(ACK, 0, rep);

        // Enough green transactions to saturate green and txn counters.
        repeat (8) begin
            send(4'b0011, 0, rep);
            send(ACK, 0, rep);
        end

        // Reset in WAIT_CTR with ctr already high (rts about to rise).
        wait_sig(0, 1'b1, "rtr_ready_rst");
        v_out = 4'b0011;
        cts   = 1'b1;
        @(negedge clk);
        ctr = 1'b1;
        #1 rst_n = 1'b0;
        @(negedge clk);
        check_all_zero("midreset");
        m_g = 0; m_r = 0; m_t = 0; m_e = 0; m_rounds = 0; m_tallied = 0;
        ctr = 1'b0; cts = 1'b0; rst_n = 1'b1;

        // Randomized transactions, mixing echoes of the reply with fresh words.
        last = 4'b0000;
        for (int t = 0; t < 20; t++) begin
            nw    = $urandom_range(1, 5);
            ended = 0;
            for (int k = 0; k < nw && !ended; k++) begin
                if (k > 0 && ($urandom % 2) == 1) w = last;
                else                            w = 4'($urandom % 16);
                send(w, $urandom % 4, rep);
                last = rep;
                if (w == ACK) ended = 1;
            end
            if (!ended) send(ACK, 0, rep);
        end

        repeat (3) @(negedge clk);
        check("sb_drained", sb_q.size(), 32'd0);
        check("abort_low", {31'b0, abort}, 32'd0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL global_timeout: bench did not finish");
        $fatal(1, "global timeout");
    end

endmodule
`default_nettype wire

// File: doc/b10_peer.md
Name: b10_peer

Overview:
- Remote counterpart station for the b10 voting terminal. Sits directly downstream of b10's vote transmitter and closes its handshake loop.
- Consumes b10's v_out/cts/ctr and produces b10's rtr/rts/v_in.
- Checks vote-word parity and tallies green/red votes.
- Replies with either a parity-corrected echo or the terminating ACK word, so each b10 transaction ends in END_TX.

Parameters:
- CNT_W, 8: width of each tally/statistics counter (saturating).
- MAX_ROUNDS, 4: bad-parity rounds tolerated per transaction before ACK is forced.
- TIMEOUT, 1024: watchdog limit in cycles; used only with PEER_TIMEOUT_EN.

Ports:
- clock  in  1  single clock; all inputs synchronous to it, no synchronizers.
- reset  in  1  asynchronous, active-low; asserted when 0.
- enable  in  1  allow a new transaction; sampled only in IDLE.
- cts  in  1  from b10: word valid on v_out / link clear.
- ctr  in  1  from b10: b10 ready to receive the reply.
- v_out  in  4  from b10: vote word {parity, red, green, key}.
- rtr  out  1  to b10: peer ready to receive.
- rts  out  1  to b10: reply valid on v_in.
- v_in  out  4  to b10: reply word.
- green_cnt  out  CNT_W  accepted green votes.
- red_cnt  out  CNT_W  accepted red votes.
- txn_cnt  out  CNT_W  completed transactions.
- err_cnt  out  CNT_W  parity errors, plus timeouts when the macro is defined.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on transaction completion.
- abort  out  1  one-cycle pulse on watchdog abort; constant 0 without the macro.

Behaviour:
- All outputs are registered. Reset (async, reset=0) forces the state to IDLE and drives every output and internal register to 0. This includes mid-transaction reset.
- Parity is good when w[3] == w[2]^w[1]^w[0]. ACK word = 4'b0110 (parity good).
- IDLE: rtr=0, rts=0. If enable=1, go to READY and assert rtr=1 on the same edge. Clear the round count and the tallied flag.
- READY: hold rtr=1 and wait for cts=1. On the sampling edge:
  - Capture v_out as w.
  - If w==ACK: go to END_WAIT and drop rtr on the same edge.
  - Otherwise, if parity is bad: err_cnt+1, rounds+1.
  - Otherwise, if parity is good and tallied=0: green_cnt+=w[1], red_cnt+=w[2], set tallied.
  - Reply register = ACK if parity is good or rounds (after increment) >= MAX_ROUNDS; else {w[2]^w[1]^w[0], w[2:0]}.
  - Go to WAIT_CTR.
- WAIT_CTR: wait for ctr=1. Then v_in <= reply, rts <= 1, go to WAIT_CTR_LOW.
- WAIT_CTR_LOW: wait for ctr=0 (b10 has sampled). Then rts <= 0, rtr <= 0, go to WAIT_CTS_LOW.
- WAIT_CTS_LOW: wait for cts=0. Then rtr <= 1, go to READY. rtr never rises while cts=1.
- END_WAIT: rtr=0; wait for cts=0. Then txn_cnt+1, pulse done, go to IDLE.
  - If enable is still 1, IDLE re-arms on the next cycle. IDLE always costs one cycle between transactions.
- v_in holds its last value except when loaded in WAIT_CTR.
- Counters saturate at 2^CNT_W-1; no wrap.
- Simultaneous bad parity and rounds reaching MAX_ROUNDS: the error is counted and ACK is still sent.
- enable=0 mid-transaction is ignored; the transaction runs to END_WAIT.
- A word with parity good and w[2:1]=00 sets tallied but adds nothing to the tallies.

Optional Feature:
- Macro: PEER_TIMEOUT_EN.
- Defined:
  - A watchdog counter clears on every state change and increments each cycle spent in READY, WAIT_CTR, WAIT_CTR_LOW, WAIT_CTS_LOW or END_WAIT.
  - When it reaches TIMEOUT: go to IDLE with rtr=0, rts=0. Pulse abort for one cycle, err_cnt+1, txn_cnt unchanged, no done pulse.
- Undefined: no watchdog logic; abort is tied to 0; the peer waits indefinitely.

Test Plan:
- Reset: hold reset=0 mid-transaction, in WAIT_CTR with rts pending -> next cycle rtr=0, rts=0, v_in=0, all counters 0, busy=0.
- Good vote: enable=1, b10 sends 4'b0011 (key, green, parity 0^1^1=0 -> w[3]=0), then 4'b0110 -> v_in=4'b0110 after ctr rises; green_cnt=1, red_cnt=0, txn_cnt=1, one done pulse.
- Bad parity: b10 sends 4'b1101 -> err_cnt=1, v_in=4'b0101; b10 echoes 4'b0101 -> red_cnt=1, v_in=4'b0110; then 4'b0110 ends the transaction with txn_cnt=1.
- Forced ACK: MAX_ROUNDS=2, b10 sends 4'b1000 twice -> first reply 4'b0000; second word 4'b1000 again -> err_cnt=2, reply 4'b0110.
- Handshake ordering: hold cts=1 for 10 cycles after ctr falls -> rtr stays 0 throughout; rtr rises exactly one cycle after cts=0 is sampled.
- Saturation / watchdog: CNT_W=2, run 5 green votes -> green_cnt=3. With PEER_TIMEOUT_EN and TIMEOUT=16, stall ctr=0 in WAIT_CTR -> abort pulse at cycle 16, err_cnt+1, state IDLE.
